// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception types, ExcCodes, field positions.
package cp0_reg_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INT_W  = 6;
  localparam int unsigned CODE_W = 5;

  localparam logic [ADDR_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [ADDR_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [ADDR_W-1:0] REG_STATUS  = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE   = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC     = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID    = 5'd15;
  localparam logic [ADDR_W-1:0] REG_CONFIG  = 5'd16;

  localparam logic [REG_W-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [REG_W-1:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [REG_W-1:0] EXC_INV     = 32'h0000_000a;
  localparam logic [REG_W-1:0] EXC_OV      = 32'h0000_000c;
  localparam logic [REG_W-1:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [REG_W-1:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [CODE_W-1:0] {
    CODE_INT = 5'd0,
    CODE_SYS = 5'd8,
    CODE_RI  = 5'd10,
    CODE_OV  = 5'd12,
    CODE_TR  = 5'd13
  } exc_code_e;

  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned CAUSE_BD      = 31;
  localparam int unsigned CAUSE_IPHW_HI = 15;
  localparam int unsigned CAUSE_IPHW_LO = 10;
  localparam int unsigned CAUSE_EXC_HI  = 6;
  localparam int unsigned CAUSE_EXC_LO  = 2;

  // Software-writable Cause bits: IV, WP and IP[1:0]
  localparam logic [REG_W-1:0] CAUSE_WMASK = 32'h00c0_0300;

  localparam logic [REG_W-1:0] PRID_DEF   = 32'h004c_0102;
  localparam logic [REG_W-1:0] CONFIG_DEF = 32'h0000_8000;
  localparam logic [REG_W-1:0] STATUS_DEF = 32'h1000_0000;

endpackage

// File: rtl/cp0_reg_if.sv
// Pipeline-side bus of the CP0 register file: writes, reads, exception commit, register views.
interface cp0_reg_if;
  import cp0_reg_pkg::*;

  logic                we_i;
  logic [ADDR_W-1:0]   waddr_i;
  logic [ADDR_W-1:0]   raddr_i;
  logic [REG_W-1:0]    data_i;
  logic [INT_W-1:0]    int_i;
  logic [REG_W-1:0]    excepttype_i;
  logic [REG_W-1:0]    current_inst_addr_i;
  logic                is_in_delayslot_i;

  logic [REG_W-1:0]    data_o;
  logic [REG_W-1:0]    count_o;
  logic [REG_W-1:0]    compare_o;
  logic [REG_W-1:0]    status_o;
  logic [REG_W-1:0]    cause_o;
  logic [REG_W-1:0]    epc_o;
  logic [REG_W-1:0]    config_o;
  logic [REG_W-1:0]    prid_o;
  logic                timer_int_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare pair and timer interrupt; implemented only when CP0_TIMER_EN is defined,
// otherwise both registers read 0 and the interrupt is tied low.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  data,
  output logic [REG_W-1:0]  count,
  output logic [REG_W-1:0]  compare,
  output logic              timer_int
);

`ifdef CP0_TIMER_EN
  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (waddr == REG_COUNT);
  assign wr_compare = we && (waddr == REG_COMPARE);

  // A Compare write acknowledges the interrupt and takes priority over a new match
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= wr_count ? data : count + REG_W'(1);
      if (wr_compare) begin
        compare   <= data;
        timer_int <= 1'b0;
      end else if ((compare != '0) && (count == compare)) begin
        timer_int <= 1'b1;
      end
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{clk, rst, we, waddr, data};
  assign count     = '0;
  assign compare   = '0;
  assign timer_int = 1'b0;
`endif

endmodule

// File: rtl/cp0_reg.sv
// MIPS Coprocessor-0 register file: Status/Cause/EPC, exception recording, read mux.
// Count/Compare and the timer interrupt exist only when CP0_TIMER_EN is defined.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [REG_W-1:0] PRID       = PRID_DEF,
  parameter logic [REG_W-1:0] CONFIG_RST = CONFIG_DEF,
  parameter logic [REG_W-1:0] STATUS_RST = STATUS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  cp0_reg_if.slave   bus
);

  logic [REG_W-1:0] status, status_nxt;
  logic [REG_W-1:0] cause, cause_nxt;
  logic [REG_W-1:0] epc, epc_nxt;
  logic [REG_W-1:0] count, compare;
  logic             timer_int;
  logic [REG_W-1:0] rdata;
  logic             take;
  logic             record;
  exc_code_e        code;

  cp0_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.we_i),
    .waddr     (bus.waddr_i),
    .data      (bus.data_i),
    .count     (count),
    .compare   (compare),
    .timer_int (timer_int)
  );

  // Software write lands first; exception updates then override the fields they own
  always_comb begin
    status_nxt = status;
    cause_nxt  = cause;
    epc_nxt    = epc;
    take       = 1'b0;
    record     = 1'b0;
    code       = CODE_INT;

    cause_nxt[CAUSE_IPHW_HI:CAUSE_IPHW_LO] = bus.int_i;

    if (bus.we_i) begin
      case (bus.waddr_i)
        REG_STATUS: status_nxt = bus.data_i;
        REG_CAUSE:  cause_nxt  = (cause_nxt & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
        REG_EPC:    epc_nxt    = bus.data_i;
        default: ;
      endcase
    end

    // Interrupts always record EPC/BD; other exceptions only outside EXL
    case (bus.excepttype_i)
      EXC_INT:     begin take = 1'b1; record = 1'b1;                 code = CODE_INT; end
      EXC_SYSCALL: begin take = 1'b1; record = ~status[STATUS_EXL]; code = CODE_SYS; end
      EXC_INV:     begin take = 1'b1; record = ~status[STATUS_EXL]; code = CODE_RI;  end
      EXC_OV:      begin take = 1'b1; record = ~status[STATUS_EXL]; code = CODE_OV;  end
      EXC_TRAP:    begin take = 1'b1; record = ~status[STATUS_EXL]; code = CODE_TR;  end
      EXC_ERET:    status_nxt[STATUS_EXL] = 1'b0;
      default: ;
    endcase

    if (record) begin
      epc_nxt = bus.is_in_delayslot_i ? bus.current_inst_addr_i - REG_W'(4)
                                      : bus.current_inst_addr_i;
      cause_nxt[CAUSE_BD] = bus.is_in_delayslot_i;
    end
    if (take) begin
      status_nxt[STATUS_EXL]                = 1'b1;
      cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO]  = code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      status <= status_nxt;
      cause  <= cause_nxt;
      epc    <= epc_nxt;
    end
  end

  // Read port shows registered state only; same-cycle writes are not bypassed
  always_comb begin
    rdata = '0;
    case (bus.raddr_i)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_STATUS:  rdata = status;
      REG_CAUSE:   rdata = cause;
      REG_EPC:     rdata = epc;
      REG_PRID:    rdata = PRID;
      REG_CONFIG:  rdata = CONFIG_RST;
      default: ;
    endcase
  end

  assign bus.data_o      = rdata;
  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.config_o    = CONFIG_RST;
  assign bus.prid_o      = PRID;
  assign bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus randomized traffic against a field-level model.
module tb_cp0_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_reg_if bus ();

  cp0_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state, Cause kept as separate fields
  logic [31:0] m_count, m_compare, m_status, m_epc;
  logic        m_tint, m_bd, m_iv, m_wp;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_cause();
    return {m_bd, 7'd0, m_iv, m_wp, 6'd0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h004c0102;
      5'd16:   return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_tint = 0; m_status = 32'h10000000; m_epc = 0;
    m_bd = 0; m_iv = 0; m_wp = 0; m_iphw = 0; m_ipsw = 0; m_exc = 0;
  endtask

  task automatic model_step(input logic r, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] ex,
                            input logic [31:0] pc, input logic ds, input logic [5:0] irq);
    logic old_exl;
    if (r) begin
      model_reset();
    end else begin
      old_exl = m_status[1];
`ifdef CP0_TIMER_EN
      begin
        logic [31:0] oc, ocmp;
        oc = m_count; ocmp = m_compare;
        m_count = (we && wa == 5'd9) ? wd : oc + 32'd1;
        if (we && wa == 5'd11) begin m_compare = wd; m_tint = 0; end
        else if (ocmp != 0 && oc == ocmp) m_tint = 1;
      end
`endif
      m_iphw = irq;
      if (we) begin
        case (wa)
          5'd12: m_status = wd;
          5'd13: begin m_ipsw = wd[9:8]; m_wp = wd[22]; m_iv = wd[23]; end
          5'd14: m_epc = wd;
          default: ;
        endcase
      end
      if (ex == 1 || ex == 8 || ex == 10 || ex == 12 || ex == 13) begin
        if (ex == 1 || !old_exl) begin
          m_epc = ds ? pc - 32'd4 : pc;
          m_bd  = ds;
        end
        m_status[1] = 1'b1;
        m_exc = (ex == 1) ? 5'd0 : ex[4:0];
      end else if (ex == 14) begin
        m_status[1] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0; bus.int_i = 0;
    bus.excepttype_i = 0; bus.current_inst_addr_i = 0; bus.is_in_delayslot_i = 0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1; bus.waddr_i = a; bus.data_i = d;
    tick();
    bus.we_i = 0;
  endtask

  task automatic do_exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    bus.excepttype_i = t; bus.current_inst_addr_i = pc; bus.is_in_delayslot_i = ds;
    tick();
    bus.excepttype_i = 0; bus.is_in_delayslot_i = 0;
  endtask

  task automatic test_reset();
    idle(); bus.raddr_i = 5'd15;
    rst = 1; tick(); tick();
    checks++; if (bus.status_o !== 32'h10000000) begin errors++; $display("FAIL reset_status got %h want %h", bus.status_o, 32'h10000000); end
    checks++; if (bus.config_o !== 32'h00008000) begin errors++; $display("FAIL reset_config got %h want %h", bus.config_o, 32'h00008000); end
    checks++; if (bus.prid_o !== 32'h004c0102) begin errors++; $display("FAIL reset_prid got %h want %h", bus.prid_o, 32'h004c0102); end
    checks++; if (bus.data_o !== 32'h004c0102) begin errors++; $display("FAIL reset_read_prid got %h want %h", bus.data_o, 32'h004c0102); end
    checks++; if ({bus.cause_o, bus.epc_o, bus.count_o, bus.compare_o} !== 128'h0 || bus.timer_int_o !== 1'b0) begin
      errors++; $display("FAIL reset_zero got cause %h epc %h count %h cmp %h tint %b want all 0", bus.cause_o, bus.epc_o, bus.count_o, bus.compare_o, bus.timer_int_o); end
    rst = 0; tick();
`ifdef CP0_TIMER_EN
    checks++; if (bus.count_o !== 32'd1) begin errors++; $display("FAIL reset_count_next got %h want %h", bus.count_o, 32'd1); end
`else
    checks++; if (bus.count_o !== 32'd0) begin errors++; $display("FAIL reset_count_next got %h want %h", bus.count_o, 32'd0); end
`endif
  endtask

  task automatic test_timer();
    apply_reset();
`ifdef CP0_TIMER_EN
    begin
      int n;
      do_write(5'd11, 32'd20);
      n = 0;
      while (bus.count_o !== 32'd20 && n < 100) begin tick(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL timer_wait got count %h want %h", bus.count_o, 32'd20); end
      checks++; if (bus.timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_early got %b want 0", bus.timer_int_o); end
      tick();
      checks++; if (bus.timer_int_o !== 1'b1) begin errors++; $display("FAIL timer_rise got %b want 1", bus.timer_int_o); end
      tick();
      checks++; if (bus.timer_int_o !== 1'b1) begin errors++; $display("FAIL timer_hold got %b want 1", bus.timer_int_o); end
      do_write(5'd11, 32'd100);
      checks++; if (bus.timer_int_o !== 1'b0 || bus.compare_o !== 32'd100) begin
        errors++; $display("FAIL timer_clear got tint %b cmp %h want 0 %h", bus.timer_int_o, bus.compare_o, 32'd100); end
    end
`else
    do_write(5'd9, 32'h1234);
    do_write(5'd11, 32'd5);
    bus.raddr_i = 5'd9;
    tick();
    checks++; if (bus.count_o !== 0 || bus.compare_o !== 0 || bus.data_o !== 0 || bus.timer_int_o !== 0) begin
      errors++; $display("FAIL timer_off got count %h cmp %h rd %h tint %b want 0", bus.count_o, bus.compare_o, bus.data_o, bus.timer_int_o); end
`endif
  endtask

  task automatic test_syscall_nested();
    apply_reset();
    do_exc(32'h8, 32'h1004, 1'b1);
    checks++; if (bus.epc_o !== 32'h1000) begin errors++; $display("FAIL sys_epc got %h want %h", bus.epc_o, 32'h1000); end
    checks++; if (bus.cause_o !== 32'h80000020) begin errors++; $display("FAIL sys_cause got %h want %h", bus.cause_o, 32'h80000020); end
    checks++; if (bus.status_o !== 32'h10000002) begin errors++; $display("FAIL sys_status got %h want %h", bus.status_o, 32'h10000002); end
    do_exc(32'hc, 32'h2000, 1'b0);
    checks++; if (bus.epc_o !== 32'h1000 || bus.cause_o !== 32'h80000030) begin
      errors++; $display("FAIL nested_ov got epc %h cause %h want %h %h", bus.epc_o, bus.cause_o, 32'h1000, 32'h80000030); end
    do_exc(32'h1, 32'h3000, 1'b0);
    checks++; if (bus.epc_o !== 32'h3000 || bus.cause_o !== 32'h0 || bus.status_o !== 32'h10000002) begin
      errors++; $display("FAIL nested_int got epc %h cause %h status %h want %h %h %h", bus.epc_o, bus.cause_o, bus.status_o, 32'h3000, 32'h0, 32'h10000002); end
    do_exc(32'h7, 32'h4000, 1'b1);
    checks++; if (bus.epc_o !== 32'h3000 || bus.status_o !== 32'h10000002) begin
      errors++; $display("FAIL unknown_exc got epc %h status %h want %h %h", bus.epc_o, bus.status_o, 32'h3000, 32'h10000002); end
    do_exc(32'he, 32'h0, 1'b0);
    checks++; if (bus.status_o !== 32'h10000000 || bus.epc_o !== 32'h3000) begin
      errors++; $display("FAIL eret got status %h epc %h want %h %h", bus.status_o, bus.epc_o, 32'h10000000, 32'h3000); end
  endtask

  task automatic test_cause_mask();
    apply_reset();
    bus.int_i = 6'b101010;
    do_write(5'd13, 32'hffffffff);
    checks++; if (bus.cause_o !== 32'h00c0ab00) begin errors++; $display("FAIL cause_mask got %h want %h", bus.cause_o, 32'h00c0ab00); end
    do_write(5'd15, 32'h0);
    do_write(5'd16, 32'h0);
    checks++; if (bus.prid_o !== 32'h004c0102 || bus.config_o !== 32'h00008000) begin
      errors++; $display("FAIL ro_regs got prid %h cfg %h want %h %h", bus.prid_o, bus.config_o, 32'h004c0102, 32'h00008000); end
    bus.raddr_i = 5'd3;
    #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want %h", bus.data_o, 32'h0); end
    bus.raddr_i = 5'd12;
    bus.we_i = 1; bus.waddr_i = 5'd12; bus.data_i = 32'h0000ff01;
    #1;
    checks++; if (bus.data_o !== 32'h10000000) begin errors++; $display("FAIL no_bypass got %h want %h", bus.data_o, 32'h10000000); end
    tick(); bus.we_i = 0;
    checks++; if (bus.data_o !== 32'h0000ff01) begin errors++; $display("FAIL status_read got %h want %h", bus.data_o, 32'h0000ff01); end
  endtask

  task automatic test_collision();
    apply_reset();
    bus.we_i = 1; bus.waddr_i = 5'd14; bus.data_i = 32'h5555;
    do_exc(32'h8, 32'h3000, 1'b0);
    checks++; if (bus.epc_o !== 32'h3000 || bus.status_o !== 32'h10000002 || bus.cause_o !== 32'h20) begin
      errors++; $display("FAIL collide_epc got epc %h status %h cause %h want %h %h %h", bus.epc_o, bus.status_o, bus.cause_o, 32'h3000, 32'h10000002, 32'h20); end
    bus.we_i = 1; bus.waddr_i = 5'd12; bus.data_i = 32'hffffffff;
    do_exc(32'he, 32'h0, 1'b0);
    checks++; if (bus.status_o !== 32'hfffffffd) begin errors++; $display("FAIL write_eret got %h want %h", bus.status_o, 32'hfffffffd); end
  endtask

  task automatic test_random();
    logic [4:0]  wtab [8];
    logic [31:0] etab [11];
    logic        r;
    wtab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    etab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h7};
    apply_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      rst = r;
      bus.we_i = 1'($urandom_range(0, 1));
      bus.waddr_i = wtab[$urandom_range(0, 7)];
      bus.data_i = $urandom;
      if (bus.waddr_i == 5'd11 && $urandom_range(0, 1) == 1) bus.data_i = m_count + 32'd3;
      bus.excepttype_i = etab[$urandom_range(0, 10)];
      bus.current_inst_addr_i = $urandom & 32'hfffffffc;
      bus.is_in_delayslot_i = 1'($urandom_range(0, 1));
      bus.int_i = 6'($urandom_range(0, 63));
      bus.raddr_i = wtab[$urandom_range(0, 7)];
      model_step(r, bus.we_i, bus.waddr_i, bus.data_i, bus.excepttype_i,
                 bus.current_inst_addr_i, bus.is_in_delayslot_i, bus.int_i);
      tick();
      checks++; if (bus.status_o !== m_status) begin errors++; $display("FAIL rnd_status cyc %0d got %h want %h", i, bus.status_o, m_status); end
      checks++; if (bus.cause_o !== m_cause()) begin errors++; $display("FAIL rnd_cause cyc %0d got %h want %h", i, bus.cause_o, m_cause()); end
      checks++; if (bus.epc_o !== m_epc) begin errors++; $display("FAIL rnd_epc cyc %0d got %h want %h", i, bus.epc_o, m_epc); end
      checks++; if (bus.count_o !== m_count || bus.compare_o !== m_compare) begin
        errors++; $display("FAIL rnd_timer_regs cyc %0d got %h %h want %h %h", i, bus.count_o, bus.compare_o, m_count, m_compare); end
      checks++; if (bus.timer_int_o !== m_tint) begin errors++; $display("FAIL rnd_tint cyc %0d got %b want %b", i, bus.timer_int_o, m_tint); end
      checks++; if (bus.data_o !== m_read(bus.raddr_i)) begin
        errors++; $display("FAIL rnd_read cyc %0d addr %0d got %h want %h", i, bus.raddr_i, bus.data_o, m_read(bus.raddr_i)); end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    clk = 0; rst = 1; checks = 0; errors = 0;
    idle(); bus.raddr_i = 0;
    test_reset();
    test_timer();
    test_syscall_nested();
    test_cause_mask();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the MIPS pipeline.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Generates the timer interrupt and records exception state.
- Upstream of the pipeline control unit: its EPC output is that unit's exception-return target. It consumes the exception type committed by the mem stage and CP0 writes retired by the wb stage.

Parameters:
- PRID, 32'h004c0102, read-only Processor ID value.
- CONFIG_RST, 32'h00008000, Config reset/constant value (BE=1).
- STATUS_RST, 32'h10000000, Status reset value (CU0=1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we_i  in  1  CP0 write enable (mtc0 at wb)
- waddr_i  in  5  CP0 register number to write
- raddr_i  in  5  CP0 register number to read
- data_i  in  32  write data
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  committed exception code from mem stage (0 = none)
- current_inst_addr_i  in  32  PC of the instruction taking the exception
- is_in_delayslot_i  in  1  that instruction sits in a branch delay slot
- data_o  out  32  read data for raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  current register values
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Reset (rst=1 at posedge):
  - Count, Compare, Cause, EPC = 0.
  - Status = STATUS_RST.
  - timer_int_o = 0.
  - config_o = CONFIG_RST and prid_o = PRID at all times.
- Register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
- Count: increments by 1 every non-reset cycle and wraps 32'hffffffff -> 0. A write loads data_i; the increment is not applied that cycle.
- Timer: if Compare != 0 and Count == Compare, timer_int_o <= 1 on the next edge. It stays set until Compare is written; the write clears it in the same edge.
- Cause:
  - Cause[15:10] <= int_i every cycle (1-cycle sample).
  - Writes affect only IP[1:0] (bits 9:8), WP (22) and IV (23); all other bits are hardware-only.
- Status: fully writable. EPC: fully writable. PRId and Config: writes ignored.
- data_o: combinational mux of the registered values by raddr_i; unmapped addresses return 0. There is no bypass of a same-cycle write; forwarding is the ex stage's job.
- Exception handling on the edge where excepttype_i != 0:
  - Recording rule, applied only when Status.EXL (bit 1) == 0: EPC <= current_inst_addr_i - 4 if is_in_delayslot_i, else current_inst_addr_i; Cause.BD (31) <= is_in_delayslot_i.
  - In all cases Status.EXL <= 1 and ExcCode <= code.
  - 0x1 interrupt: ExcCode 0. EPC/BD are always recorded, regardless of EXL.
  - 0x8 syscall: ExcCode 8.
  - 0xa invalid instruction: ExcCode 10.
  - 0xd trap: ExcCode 13.
  - 0xc overflow: ExcCode 12.
  - 0xe eret: Status.EXL <= 0 only.
  - Any other nonzero code: no change.
- Simultaneous write and exception: the software write applies first and exception updates override the fields they touch (EPC, Status.EXL, Cause.BD/ExcCode).
- Write plus eret in the same cycle: Status gets data_i with EXL forced to 0.
- Reset mid-exception: reset wins; all state returns to reset values.
- Latency: every write is visible on outputs 1 cycle later.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare registers and timer_int_o behave as above.
- Undefined: Count and Compare are not implemented; they read 0 and writes are ignored; timer_int_o is tied 0.

Decomposition:
- Shared defines: CP0 register numbers, exception-type codes (0x1, 0x8, 0xa, 0xc, 0xd, 0xe), ExcCode values, Status/Cause bit positions, RegBus.
- Sub-module cp0_timer holds Count/Compare/timer_int_o under CP0_TIMER_EN. Everything else stays flat.

Test Plan:
- Reset: assert rst 2 cycles -> status_o=32'h10000000, config_o=32'h00008000, prid_o=32'h004c0102, all other outputs 0; next cycle count_o=1.
- Timer: write Compare=20 (Count reset at 0) -> timer_int_o rises one edge after count_o==20; writing Compare=100 clears it on that edge.
- Syscall in delay slot: excepttype_i=0x8, addr=0x1004, delayslot=1 -> epc_o=0x1000, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
- Nested exception: with EXL=1, overflow 0xc at addr 0x2000 -> epc_o unchanged, ExcCode=12; then eret 0xe -> status_o[1]=0.
- Cause write mask: write Cause=32'hffffffff with int_i=6'b101010 -> cause_o=32'h00c0ab00 one cycle later.
- Collision: write EPC=0x5555 and syscall at 0x3000 in the same cycle -> epc_o=0x3000.
